// File: rtl/demux_1h_buf.sv
// One-hot demultiplexer: routes a valid/ready input stream into N one-entry
// registered output lanes; beats with an illegal select are dropped and counted.
module demux_1h_buf #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_select,
  input  logic [WIDTH-1:0] in_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data [N],
  output logic             err_select,
  output logic [CNT_W-1:0] drop_count
);

  logic [N-1:0]     valid_q, valid_d;
  logic [WIDTH-1:0] data_q [N];
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0] can_accept;
  logic [N-1:0] wr_en;
  logic         sel_legal;
  logic         drop;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_legal  = (|in_select) &&
                      ((in_select & (in_select - {{(N-1){1'b0}}, 1'b1})) == '0);
  assign can_accept = ~valid_q | out_ready;
  assign in_ready   = sel_legal ? |(in_select & can_accept) : 1'b1;
  assign drop       = in_valid && !sel_legal;

  always_comb begin
    wr_en   = '0;
    valid_d = valid_q & ~out_ready;
    err_d   = drop;
    cnt_d   = cnt_q;
    if (in_valid && sel_legal) begin
      wr_en = in_select & can_accept;
    end
    valid_d = valid_d | wr_en;
    if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < N; k++) begin
        if (wr_en[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign err_select = err_q;
  assign drop_count = cnt_q;

endmodule
